rez_sched: RTL and testbench
============================

REZ_SCHED -- requirements
Module: rez_sched

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; clock port named clk, reset port named reset.
REQ-002 clk  input  1  system clock, 14 MHz, same clock as the display timing generator.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 vs  input  1  display vertical sync; positive pulse; synchronous to clk.
REQ-005 freeze  input  1  when 1, frame commits are suppressed.
REQ-006 req0_valid / req1_valid  input  1 each  requester N offers a write.
REQ-007 req0_sel / req1_sel  input  2 each  target slot: 0=rez1, 1=rez2, 2=rez3, 3=rez4.
REQ-008 req0_data / req1_data  input  32 each  write data; slots 2/3 use bits [5:0] only.
REQ-009 req0_ready / req1_ready  output  1 each  write accepted this cycle (grant).
REQ-010 rez1, rez2  output  32 each  published display words.
REQ-011 rez3, rez4  output  6 each  published marker columns; 6'h3f means no marker.
REQ-012 upd  output  1  one-cycle pulse on each commit.
REQ-013 frame_cnt  output  8  count of commits, wraps.
REQ-014 pending  output  1  shadow holds writes not yet published.

Function
REQ-015 Shadow register set (S1,S2 32-bit; S3,S4 6-bit) SHALL receive accepted writes; outputs change only on commit.
REQ-016 Handshake: a write transfers when valid and ready are both 1 in the same cycle; ready is combinational from valids and arbiter state.
REQ-017 At most one request SHALL be granted per cycle; ready SHALL never be 1 while the matching valid is 0.
REQ-018 Arbitration SHALL be round-robin: a single valid is granted immediately; with both valid, grant goes to the requester not granted most recently (requester 0 after reset).
REQ-019 A requester holding valid SHALL be granted within 2 cycles.
REQ-020 The accepted write SHALL update the shadow slot on the next clk edge (1-cycle latency into shadow).
REQ-021 Commit event = rising edge of vs (vs=1 and registered previous vs=0) AND freeze=0.
REQ-022 On commit, rez1..rez4 SHALL load the shadow contents as they stood before that edge; outputs valid the cycle after the vs rising edge.
REQ-023 A write accepted in the commit cycle SHALL land in shadow and appear at the next commit, not the current one.
REQ-024 upd SHALL pulse for exactly one cycle, coincident with the new rez values; frame_cnt increments by 1 in the same cycle, 8'hff -> 8'h00.
REQ-025 pending SHALL set on any accepted write, clear on commit unless a write is accepted in that same cycle (then stays 1).
REQ-026 A vs rising edge with freeze=1 SHALL be ignored entirely (no upd, no count, pending unchanged); deasserting freeze mid-pulse SHALL NOT create a commit (edge only).
REQ-027 Writes to slots 2/3 SHALL discard data[31:6].

Reset
REQ-028 On reset: rez1=rez2=0, rez3=rez4=6'h3f, S1=S2=0, S3=S4=6'h3f, upd=0, frame_cnt=0, pending=0, previous-vs register=0, round-robin pointer favours requester 0.
REQ-029 Reset asserted mid-operation SHALL discard pending writes and all shadow contents immediately; first commit after release requires a fresh vs rising edge.

Structure
REQ-030 A shared package SHALL hold slot-index constants (SLOT_REZ1..SLOT_REZ4), REZ_MARK_NONE=6'h3f, and data widths (32, 6).
REQ-031 The two-requester round-robin arbiter SHALL be a sub-module named rr_arb2 (inputs clk, reset, two valids; outputs two one-hot grants).
REQ-032 Target size 120-400 lines RTL; no memories, registers only.

Verification
REQ-033 Reset then idle: rez1=0, rez3=6'h3f, upd=0, frame_cnt=0 for 1000 cycles with vs toggling only after writes absent -> on each vs edge upd pulses, frame_cnt counts 1,2,3, rez unchanged.
REQ-034 req0 writes sel=0 data=32'h1234ABCD; vs rises 5 cycles later -> rez1=32'h1234ABCD cycle after edge, upd=1 one cycle, pending 1->0.
REQ-035 Both valid continuously, req0 sel=1 data=A, req1 sel=1 data=B -> grants alternate 0,1,0,1; never both ready; last granted value appears in rez2 at commit.
REQ-036 Write sel=2 data=32'hFFFFFF05 in the exact vs rising-edge cycle -> rez3 keeps 6'h3f at that commit, becomes 6'h05 at next commit; pending stays 1 between.
REQ-037 freeze=1 across two vs pulses with writes to rez4=6'h10 -> no upd, frame_cnt unchanged, rez4=6'h3f; freeze=0 then next vs edge -> rez4=6'h10.
REQ-038 Assert reset asynchronously mid-frame after writing rez1=32'hDEADBEEF -> all outputs back to reset values without a clock edge; next vs edge publishes rez1=0.

Source files
------------

// File: rtl/rez_sched_pkg.sv
// Shared constants and types for the display-register scheduler: slot indices,
// data widths, the "no marker" code and the shadow/published register set layout.
package rez_sched_pkg;

  localparam int REZ_DATA_W = 32;
  localparam int REZ_MARK_W = 6;

  localparam logic [1:0] SLOT_REZ1 = 2'd0;
  localparam logic [1:0] SLOT_REZ2 = 2'd1;
  localparam logic [1:0] SLOT_REZ3 = 2'd2;
  localparam logic [1:0] SLOT_REZ4 = 2'd3;

  localparam logic [REZ_MARK_W-1:0] REZ_MARK_NONE = 6'h3f;

  typedef struct packed {
    logic [REZ_DATA_W-1:0] r1;
    logic [REZ_DATA_W-1:0] r2;
    logic [REZ_MARK_W-1:0] r3;
    logic [REZ_MARK_W-1:0] r4;
  } rez_set_t;

  function automatic rez_set_t rez_set_init();
    rez_set_t s;
    s.r1 = '0;
    s.r2 = '0;
    s.r3 = REZ_MARK_NONE;
    s.r4 = REZ_MARK_NONE;
    return s;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Grants are combinational from the valids;
// the registered pointer remembers which requester wins the next tie.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  output logic gnt0,
  output logic gnt1
);

  // prio_q = 0: requester 0 wins a tie; 1: requester 1 wins a tie
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    prio_d = prio_q;
    if (valid0 && valid1) begin
      gnt0 = ~prio_q;
      gnt1 = prio_q;
    end else begin
      gnt0 = valid0;
      gnt1 = valid1;
    end
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/rez_sched.sv
// Frame-synchronous register publisher: two requesters write a shadow set, and
// the shadow is copied to the display outputs on each unfrozen vs rising edge.
module rez_sched
  import rez_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vs,
  input  logic                  freeze,
  input  logic                  req0_valid,
  input  logic [1:0]            req0_sel,
  input  logic [REZ_DATA_W-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [1:0]            req1_sel,
  input  logic [REZ_DATA_W-1:0] req1_data,
  output logic                  req1_ready,
  output logic [REZ_DATA_W-1:0] rez1,
  output logic [REZ_DATA_W-1:0] rez2,
  output logic [REZ_MARK_W-1:0] rez3,
  output logic [REZ_MARK_W-1:0] rez4,
  output logic                  upd,
  output logic [7:0]            frame_cnt,
  output logic                  pending
);

  rez_set_t              shadow_q, shadow_d;
  rez_set_t              rez_q, rez_d;
  logic                  vs_prev_q, vs_prev_d;
  logic                  upd_q, upd_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic                  pending_q, pending_d;

  logic                  wr_en;
  logic [1:0]            wr_sel;
  logic [REZ_DATA_W-1:0] wr_data;
  logic                  commit;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .gnt0   (req0_ready),
    .gnt1   (req1_ready)
  );

  always_comb begin
    wr_en       = req0_ready | req1_ready;
    wr_sel      = req1_ready ? req1_sel  : req0_sel;
    wr_data     = req1_ready ? req1_data : req0_data;
    // Edge-only: vs_prev tracks vs even while frozen, so releasing freeze mid-pulse cannot commit.
    commit      = vs & ~vs_prev_q & ~freeze;

    shadow_d    = shadow_q;
    rez_d       = rez_q;
    vs_prev_d   = vs;
    upd_d       = commit;
    frame_cnt_d = frame_cnt_q;
    pending_d   = pending_q;

    if (wr_en) begin
      case (wr_sel)
        SLOT_REZ1: shadow_d.r1 = wr_data;
        SLOT_REZ2: shadow_d.r2 = wr_data;
        SLOT_REZ3: shadow_d.r3 = wr_data[REZ_MARK_W-1:0];
        SLOT_REZ4: shadow_d.r4 = wr_data[REZ_MARK_W-1:0];
        default:   shadow_d    = shadow_q;
      endcase
    end

    // Publishes the pre-edge shadow; a write in this same cycle waits for the next frame.
    if (commit) begin
      rez_d       = shadow_q;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    if (wr_en) begin
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q    <= rez_set_init();
      rez_q       <= rez_set_init();
      vs_prev_q   <= 1'b0;
      upd_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
      pending_q   <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      rez_q       <= rez_d;
      vs_prev_q   <= vs_prev_d;
      upd_q       <= upd_d;
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
    end
  end

  assign rez1      = rez_q.r1;
  assign rez2      = rez_q.r2;
  assign rez3      = rez_q.r3;
  assign rez4      = rez_q.r4;
  assign upd       = upd_q;
  assign frame_cnt = frame_cnt_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_rez_sched.sv
// Bench for rez_sched: a reference model predicts grants and commit contents;
// expected commits are queued at the commit edge and popped when upd is seen.
module tb_rez_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vs = 1'b0;
  logic        freeze = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0]  req0_sel = 2'd0, req1_sel = 2'd0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic [31:0] rez1, rez2;
  logic [5:0]  rez3, rez4;
  logic        upd;
  logic [7:0]  frame_cnt;
  logic        pending;

  int total = 0;
  int bad = 0;
  int upd_seen = 0;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [5:0]  r3;
    logic [5:0]  r4;
    logic [7:0]  cnt;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] m_s1, m_s2;
  logic [5:0]  m_s3, m_s4;
  logic        m_prio, m_vsp, m_pend;
  logic [7:0]  m_cnt;

  always #5 clk = ~clk;

  rez_sched dut (
    .clk        (clk),
    .reset      (reset),
    .vs         (vs),
    .freeze     (freeze),
    .req0_valid (req0_valid),
    .req0_sel   (req0_sel),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_sel   (req1_sel),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rez1       (rez1),
    .rez2       (rez2),
    .rez3       (rez3),
    .rez4       (rez4),
    .upd        (upd),
    .frame_cnt  (frame_cnt),
    .pending    (pending)
  );

  // Expected {gnt1, gnt0}: a lone valid wins, ties go to the requester not served last.
  function automatic logic [1:0] exp_gnt();
    if (req0_valid && req1_valid) return m_prio ? 2'b10 : 2'b01;
    if (req0_valid) return 2'b01;
    if (req1_valid) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_s3 = 6'h3f; m_s4 = 6'h3f;
    m_prio = 1'b0; m_vsp = 1'b0; m_pend = 1'b0; m_cnt = 8'd0;
    sbq.delete();
  endtask

  // One clock of the reference model; inputs must already be stable.
  task automatic advance();
    logic [1:0]  g;
    logic [1:0]  sel;
    logic [31:0] data;
    g = exp_gnt();
    @(posedge clk);
    if (vs && !m_vsp && !freeze) begin
      m_cnt = m_cnt + 8'd1;
      sbq.push_back('{r1: m_s1, r2: m_s2, r3: m_s3, r4: m_s4, cnt: m_cnt});
      m_pend = 1'b0;
    end
    if (g != 2'b00) begin
      sel  = g[1] ? req1_sel  : req0_sel;
      data = g[1] ? req1_data : req0_data;
      case (sel)
        2'd0: m_s1 = data;
        2'd1: m_s2 = data;
        2'd2: m_s3 = data[5:0];
        default: m_s4 = data[5:0];
      endcase
      m_pend = 1'b1;
      m_prio = g[0];
    end
    m_vsp = vs;
    #1;
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    advance();
    vs = 1'b0;
    advance();
  endtask

  // Scoreboard monitor: grants every cycle, commit contents whenever upd is high.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      total++;
      if ({req1_ready, req0_ready} !== exp_gnt()) begin
        bad++;
        $display("FAIL grant: got=%b%b want=%b", req1_ready, req0_ready, exp_gnt());
      end
      if (upd === 1'b1) begin
        upd_seen++;
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_upd: got upd=1 want no commit");
        end else begin
          e = sbq.pop_front();
          if (rez1 !== e.r1 || rez2 !== e.r2 || rez3 !== e.r3 || rez4 !== e.r4 || frame_cnt !== e.cnt) begin
            bad++;
            $display("FAIL commit: got %h %h %h %h cnt=%0d want %h %h %h %h cnt=%0d",
                     rez1, rez2, rez3, rez4, frame_cnt, e.r1, e.r2, e.r3, e.r4, e.cnt);
          end else begin
            $display("commit ok: rez1=%h rez2=%h rez3=%h rez4=%h cnt=%0d", rez1, rez2, rez3, rez4, frame_cnt);
          end
        end
      end
    end
  end

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if (rez1 !== 32'h0 || rez2 !== 32'h0 || rez3 !== 6'h3f || rez4 !== 6'h3f ||
        upd !== 1'b0 || frame_cnt !== 8'd0 || pending !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got %h %h %h %h upd=%b cnt=%0d pend=%b want 0 0 3f 3f 0 0 0",
               rez1, rez2, rez3, rez4, upd, frame_cnt, pending);
    end
    $display("reset checked");
  endtask

  task automatic test_idle_vs();
    int base;
    base = upd_seen;
    repeat (200) advance();
    total++;
    if (frame_cnt !== 8'd0 || upd_seen != base) begin
      bad++;
      $display("FAIL idle_quiet: got cnt=%0d upds=%0d want cnt=0 upds=0", frame_cnt, upd_seen - base);
    end
    for (int k = 1; k <= 3; k++) begin
      vs_pulse();
      repeat (3) advance();
      total++;
      if (frame_cnt !== 8'(k) || rez1 !== 32'h0 || rez3 !== 6'h3f) begin
        bad++;
        $display("FAIL idle_commit: got cnt=%0d rez1=%h rez3=%h want cnt=%0d rez1=0 rez3=3f", frame_cnt, rez1, rez3, k);
      end
    end
    total++;
    if (upd_seen - base != 3) begin
      bad++;
      $display("FAIL idle_upd_count: got %0d want 3", upd_seen - base);
    end
  endtask

  task automatic test_single_write();
    req0_valid = 1'b1; req0_sel = 2'd0; req0_data = 32'h1234ABCD;
    @(negedge clk);
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_grant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    advance();
    req0_valid = 1'b0;
    @(negedge clk);
    total++;
    if (pending !== 1'b1 || rez1 !== 32'h0) begin
      bad++;
      $display("FAIL single_shadow: got pend=%b rez1=%h want 1 0", pending, rez1);
    end
    repeat (4) advance();
    vs = 1'b1;
    advance();
    total++;
    if (rez1 !== 32'h1234ABCD || upd !== 1'b1 || pending !== 1'b0) begin
      bad++;
      $display("FAIL single_commit: got rez1=%h upd=%b pend=%b want 1234abcd 1 0", rez1, upd, pending);
    end
    vs = 1'b0;
    advance();
    total++;
    if (upd !== 1'b0) begin
      bad++;
      $display("FAIL upd_width: got upd=%b want 0", upd);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  g, prev_g;
    logic [31:0] last_data;
    prev_g = 2'b00;
    last_data = '0;
    req0_valid = 1'b1; req0_sel = 2'd1; req0_data = 32'hAAAA0001;
    req1_valid = 1'b1; req1_sel = 2'd1; req1_data = 32'hBBBB0002;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      g = {req1_ready, req0_ready};
      total++;
      if (!(g == 2'b01 || g == 2'b10) || (i > 0 && g == prev_g)) begin
        bad++;
        $display("FAIL alternate: cycle %0d got=%b prev=%b want one-hot alternating", i, g, prev_g);
      end
      prev_g = g;
      last_data = g[1] ? 32'hBBBB0002 : 32'hAAAA0001;
      advance();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    vs = 1'b1;
    advance();
    total++;
    if (rez2 !== last_data) begin
      bad++;
      $display("FAIL b2b_rez2: got %h want %h", rez2, last_data);
    end
    vs = 1'b0;
    advance();
  endtask

  task automatic test_commit_cycle_write();
    req0_valid = 1'b1; req0_sel = 2'd2; req0_data = 32'hFFFFFF05;
    vs = 1'b1;
    advance();
    req0_valid = 1'b0;
    total++;
    if (upd !== 1'b1 || rez3 !== 6'h3f || pending !== 1'b1) begin
      bad++;
      $display("FAIL edge_write_first: got upd=%b rez3=%h pend=%b want 1 3f 1", upd, rez3, pending);
    end
    vs = 1'b0;
    repeat (3) advance();
    total++;
    if (pending !== 1'b1 || rez3 !== 6'h3f) begin
      bad++;
      $display("FAIL edge_write_between: got pend=%b rez3=%h want 1 3f", pending, rez3);
    end
    vs_pulse();
    total++;
    if (rez3 !== 6'h05 || pending !== 1'b0) begin
      bad++;
      $display("FAIL edge_write_next: got rez3=%h pend=%b want 05 0", rez3, pending);
    end
  endtask

  task automatic test_freeze();
    logic [7:0] cnt0;
    int         base;
    cnt0 = m_cnt;
    base = upd_seen;
    freeze = 1'b1;
    req1_valid = 1'b1; req1_sel = 2'd3; req1_data = 32'hABCDEF10;
    advance();
    req1_valid = 1'b0;
    repeat (2) begin
      vs_pulse();
      repeat (2) advance();
    end
    total++;
    if (frame_cnt !== cnt0 || rez4 !== 6'h3f || pending !== 1'b1 || upd_seen != base) begin
      bad++;
      $display("FAIL frozen: got cnt=%0d rez4=%h pend=%b upds=%0d want cnt=%0d 3f 1 0",
               frame_cnt, rez4, pending, upd_seen - base, cnt0);
    end
    vs = 1'b1;
    advance();
    freeze = 1'b0;
    repeat (2) advance();
    total++;
    if (frame_cnt !== cnt0 || upd_seen != base) begin
      bad++;
      $display("FAIL freeze_midpulse: got cnt=%0d upds=%0d want cnt=%0d upds=0", frame_cnt, upd_seen - base, cnt0);
    end
    vs = 1'b0;
    advance();
    vs_pulse();
    total++;
    if (rez4 !== 6'h10 || pending !== 1'b0 || frame_cnt !== cnt0 + 8'd1) begin
      bad++;
      $display("FAIL unfreeze_commit: got rez4=%h pend=%b cnt=%0d want 10 0 %0d", rez4, pending, frame_cnt, cnt0 + 8'd1);
    end
  endtask

  task automatic test_async_reset();
    req0_valid = 1'b1; req0_sel = 2'd0; req0_data = 32'hDEADBEEF;
    advance();
    req0_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (rez1 !== 32'h0 || rez2 !== 32'h0 || rez3 !== 6'h3f || rez4 !== 6'h3f ||
        upd !== 1'b0 || frame_cnt !== 8'd0 || pending !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got %h %h %h %h upd=%b cnt=%0d pend=%b want 0 0 3f 3f 0 0 0",
               rez1, rez2, rez3, rez4, upd, frame_cnt, pending);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    advance();
    vs_pulse();
    total++;
    if (rez1 !== 32'h0 || frame_cnt !== 8'd1) begin
      bad++;
      $display("FAIL post_reset_commit: got rez1=%h cnt=%0d want 0 1", rez1, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_idle_vs();
    test_single_write();
    test_back_to_back();
    test_commit_cycle_write();
    test_freeze();
    test_async_reset();
    repeat (3) advance();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL missing_upd: got %0d commits unseen want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
